// File: rtl/wavetable_reader_pkg.sv
// wavetable_reader_pkg: shared FSM state type and default widths for the wavetable reader
package wavetable_reader_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} wr_state_t;
  localparam int WR_ADDR_W = 12;
  localparam int WR_DATA_W = 32;
  localparam logic [3:0] WR_BYTEEN_ALL = 4'hF;
endpackage

// File: rtl/wavetable_reader_fifo.sv
// wavetable_reader_fifo: sync FIFO (clk, reset, flush, push/din, pop/dout, count) with same-cycle push+pop
module wavetable_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_pop;
  assign do_pop = pop && |count;
  assign dout = mem[rd];
  always_ff @(posedge clk) if (push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= push ? wr + AW'(1) : wr;
      rd <= do_pop ? rd + AW'(1) : rd;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/niosii_system_wavetable_reader.sv
// niosii_system_wavetable_reader: Avalon-MM read master (mem_*) streaming base_addr/length words to Avalon-ST (out_*) on start/stop; WAVETABLE_READER_LOOP_EN adds loop input
module niosii_system_wavetable_reader
  import wavetable_reader_pkg::*;
#(
  parameter int ADDR_W = WR_ADDR_W,
  parameter int DATA_W = WR_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef WAVETABLE_READER_LOOP_EN
  input  logic              loop,
`endif
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] ONE = 1;
  wr_state_t state, state_n;
  logic [ADDR_W-1:0] addr, base_q;
  logic [ADDR_W:0] rem, len_q;
  logic inflight, loop_q, last, pop;
  logic [CW-1:0] fifo_count;
  logic [DATA_W-1:0] fifo_dout;
  assign mem_write = 1'b0;
  assign mem_byteenable = WR_BYTEEN_ALL;
  assign mem_clken = 1'b1;
  assign mem_address = addr;
  assign mem_chipselect = state == FETCH && |rem && (fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH);
  assign last = mem_chipselect && rem == ONE;
  assign out_valid = |fifo_count;
  assign out_data = out_valid ? fifo_dout : '0;
  assign pop = out_valid && out_ready;
  assign busy = state == FETCH || state == DRAIN;
  assign done = state == FINISH;
`ifdef WAVETABLE_READER_LOOP_EN
  always_ff @(posedge clk) loop_q <= reset ? 1'b0 : (state == IDLE && start) ? loop : loop_q;
`else
  assign loop_q = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : ~|length ? FINISH : FETCH;
      FETCH:   state_n = last && !loop_q ? DRAIN : FETCH;
      DRAIN:   state_n = !inflight && (~|fifo_count || (fifo_count == CW'(1) && pop)) ? FINISH : DRAIN;
      default: state_n = IDLE;
    endcase
    if (stop) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      base_q <= '0;
      rem <= '0;
      len_q <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= mem_chipselect && !stop;
      if (state == IDLE && start) begin
        addr <= base_addr;
        base_q <= base_addr;
        rem <= length;
        len_q <= length;
      end else if (mem_chipselect) begin
        addr <= last && loop_q ? base_q : addr + ADDR_W'(1);
        rem <= last && loop_q ? len_q : rem - ONE;
      end
    end
  end
  wavetable_reader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(stop),
    .push(inflight),
    .din(mem_readdata),
    .pop(pop),
    .dout(fifo_dout),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_niosii_system_wavetable_reader.sv
// tb_niosii_system_wavetable_reader: table-driven scoreboard bench for the wavetable reader
module tb_niosii_system_wavetable_reader;
  import wavetable_reader_pkg::*;
  typedef struct {
    logic [11:0] base;
    logic [12:0] len;
    int          mode;
    int          exp_lat;
  } vec_t;
  logic clk = 0, reset = 1, start = 0, stop = 0, out_ready = 0, loop = 0;
  logic [11:0] base_addr = 0;
  logic [12:0] length = 0;
  logic busy, done, mem_chipselect, mem_write, mem_clken, out_valid;
  logic [11:0] mem_address;
  logic [3:0] mem_byteenable;
  logic [31:0] mem_readdata = 0, out_data;
  int tests = 0, fails = 0, strobes = 0, dones = 0;
  logic [31:0] exp_q[$];
  logic [11:0] addr_q[$];
  vec_t vecs[6];
  always #5 clk = ~clk;
  niosii_system_wavetable_reader dut (
    .clk(clk),
    .reset(reset),
`ifdef WAVETABLE_READER_LOOP_EN
    .loop(loop),
`endif
    .start(start),
    .stop(stop),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .mem_address(mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  function automatic logic [31:0] word(input logic [11:0] a);
    return 32'hA000_0000 + {20'h0, a};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  always @(posedge clk) mem_readdata <= mem_chipselect ? word(mem_address) : 32'hDEAD_BEEF;
  always @(negedge clk) if (!reset) begin
    if (mem_chipselect) begin
      strobes++;
      if (addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected strobe: got addr %h expected none", mem_address);
      end else chk("strobe addr", {20'h0, mem_address}, {20'h0, addr_q.pop_front()});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected word: got %h expected none", out_data);
      end else chk("out_data", out_data, exp_q.pop_front());
    end
    if (done) dones++;
  end
  task automatic expect_words(input logic [11:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      addr_q.push_back(base + 12'(k));
      exp_q.push_back(word(base + 12'(k)));
    end
  endtask
  task automatic run_vec(input vec_t v);
    int lat, done_c;
    bit fin;
    lat = 0;
    done_c = 0;
    fin = 0;
    strobes = 0;
    dones = 0;
    expect_words(v.base, int'(v.len));
    out_ready = v.mode == 0;
    base_addr = v.base;
    length = v.len;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    base_addr = 12'($urandom);
    length = 13'($urandom);
    for (int c = 1; c <= 10000 && !fin; c++) begin
      if (v.mode == 1) out_ready = c > 20;
      if (v.mode == 2) begin
        out_ready = 1'($urandom);
        start = c == 5;
      end
      if (v.mode == 1 && c == 21) chk("stall strobes", 32'(strobes), 32'd4);
      if (lat == 0 && out_valid) lat = c;
      if (done) begin
        fin = 1;
        done_c = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 0;
    chk("done seen", 32'(fin), 32'd1);
    chk("busy at done", 32'(busy), 32'd0);
    if (v.exp_lat != 0) chk("first valid latency", 32'(lat), 32'(v.exp_lat));
    if (v.mode == 0) chk("done cycle", 32'(done_c), 32'(v.len) + 32'd3);
    @(posedge clk); #1;
    chk("done single pulse", 32'(done), 32'd0);
    chk("strobe count", 32'(strobes), 32'(v.len));
    chk("done count", 32'(dones), 32'd1);
    chk("words left", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic run_abort(input bit use_reset);
    strobes = 0;
    dones = 0;
    expect_words(12'h300, 100);
    out_ready = 1;
    base_addr = 12'h300;
    length = 13'd100;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    if (use_reset) reset = 1; else stop = 1;
    @(posedge clk); #1;
    reset = 0;
    stop = 0;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort chipselect", 32'(mem_chipselect), 32'd0);
    if (use_reset) chk("reset mem_address", {20'h0, mem_address}, 32'd0);
    addr_q.delete();
    exp_q.delete();
    strobes = 0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("abort no strobes", 32'(strobes), 32'd0);
    chk("abort no done", 32'(dones), 32'd0);
    chk("abort still empty", 32'(out_valid), 32'd0);
  endtask
  initial begin
    vecs[0] = '{12'h010, 13'd4, 0, 3};
    vecs[1] = '{12'hFFE, 13'd4, 0, 3};
    vecs[2] = '{12'h040, 13'd8, 1, 0};
    vecs[3] = '{12'h100, 13'd37, 2, 0};
    vecs[4] = '{12'h800, 13'd4096, 0, 3};
    vecs[5] = '{12'hFFF, 13'd1, 0, 3};
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset chipselect", 32'(mem_chipselect), 32'd0);
    chk("reset mem_address", {20'h0, mem_address}, 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("mem_write", 32'(mem_write), 32'd0);
    chk("mem_byteenable", {28'h0, mem_byteenable}, 32'hF);
    chk("mem_clken", 32'(mem_clken), 32'd1);
    reset = 0;
    @(posedge clk); #1;
    strobes = 0;
    dones = 0;
    length = 0;
    base_addr = 12'h123;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("len0 done", 32'(done), 32'd1);
    chk("len0 busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("len0 done single", 32'(done), 32'd0);
    chk("len0 no strobes", 32'(strobes), 32'd0);
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    run_abort(1'b0);
    run_abort(1'b1);
`ifdef WAVETABLE_READER_LOOP_EN
    strobes = 0;
    dones = 0;
    for (int r = 0; r < 6; r++) expect_words(12'h020, 3);
    out_ready = 1;
    loop = 1;
    base_addr = 12'h020;
    length = 13'd3;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
    end
    chk("loop continuous strobes", 32'(strobes), 32'd12);
    chk("loop no done", 32'(dones), 32'd0);
    stop = 1;
    @(posedge clk); #1;
    stop = 0;
    loop = 0;
    chk("loop stop busy", 32'(busy), 32'd0);
    addr_q.delete();
    exp_q.delete();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/niosii_system_wavetable_reader.md
# niosII_system_wavetable_reader

Avalon-MM read master that streams a contiguous word range out of the 4096×32 on-chip memory (second, read-only slave port) into an Avalon-ST sample stream for the audio output path. Sits directly downstream of the on-chip memory. Nios II software writes a wavetable into that memory, then programs base/length and pulses `start`. The reader issues back-pressure-aware reads and buffers returning words in a small FIFO.

## Interface
Parameters:
- `ADDR_W`, 12: memory word-address width (4096 words).
- `DATA_W`, 32: memory/stream data width.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock for all logic, shared with the memory.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: one-cycle command pulse; honoured only in IDLE.
- `stop` in 1: abort request; honoured in any state.
- `base_addr` in ADDR_W: first word address, sampled on accepted `start`.
- `length` in ADDR_W+1: word count, 0..4096, sampled on accepted `start`.
- `busy` out 1: high from accepted `start` until `done` or abort completes.
- `done` out 1: one-cycle pulse after the last word is accepted downstream.
- `mem_address` out ADDR_W: read address.
- `mem_chipselect` out 1: read strobe, one word per asserted cycle.
- `mem_write` out 1: tied 0.
- `mem_byteenable` out 4: tied 4'hF.
- `mem_clken` out 1: tied 1.
- `mem_readdata` in DATA_W: valid exactly one cycle after the strobe cycle.
- `out_data` out DATA_W: FIFO head.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: downstream accept; a transfer occurs when `out_valid & out_ready`.

## Operation
- FSM states:
  - IDLE: on `start`: latch base/length, `busy`=1. If length=0, go to FINISH; otherwise go to FETCH.
  - FETCH: assert `mem_chipselect` whenever `remaining_issue > 0` and (`fifo_count` + `inflight`) < FIFO_DEPTH. `inflight` is 0 or 1. On each strobe: address+1, `remaining_issue`−1. When `remaining_issue` reaches 0, go to DRAIN.
  - DRAIN: wait until `inflight`=0 and the FIFO is empty, then go to FINISH.
  - FINISH: `done`=1 for one cycle, `busy`=0, go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. 0xFFF increments to 0x000 with no error.
- The cycle after a strobe, `mem_readdata` is pushed into the FIFO unconditionally. The credit rule guarantees a free slot.
- FIFO supports simultaneous push and pop, including when full with a pop in the same cycle.
- `stop` takes effect at the next edge:
  - Strobes cease, the FIFO is flushed, and an in-flight word is discarded.
  - FSM goes to IDLE with `busy`=0 and no `done` pulse.
  - `stop` and `start` in the same cycle: `stop` wins.
- `start` while `busy` is ignored. Base/length changes while busy have no effect.
- Reset values: `busy`=0, `done`=0, `mem_chipselect`=0, `mem_address`=0, `out_valid`=0, `out_data`=0, FIFO empty, FSM=IDLE.

## Timing
- Edge 0 samples `start`. Cycle 1: first strobe with `mem_address`=base. Cycle 2: readdata is pushed. Cycle 3: `out_valid`=1. Start-to-first-valid latency is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle and strobes are continuous.
- With `out_ready` low, at most FIFO_DEPTH words are fetched, then strobes stop. Strobing resumes the cycle after the first pop.
- `done` asserts the cycle after the last word's handshake. `busy` falls in that same cycle.

## Configuration
- `WAVETABLE_READER_LOOP_EN`:
  - Defined: an extra input `loop` (1 bit) is sampled on `start`. When latched high, reaching `remaining_issue`=0 in FETCH reloads address=base and count=length instead of entering DRAIN. Playback repeats seamlessly with no gap cycle and no `done`, until `stop` is asserted.
  - Undefined: no `loop` port; playback is always one-shot.

## Structure
- Package `wavetable_reader_pkg`:
  - FSM state enum (IDLE, FETCH, DRAIN, FINISH).
  - `WR_ADDR_W`=12, `WR_DATA_W`=32 defaults.
  - Constant `WR_BYTEEN_ALL`=4'hF.
- Sub-module `wavetable_reader_fifo`: synchronous FIFO (parameterised depth/width) with `flush` input and `count` output. The FSM/credit logic stays in the top level.

## Test plan
- base=0x010, length=4, `out_ready`=1, memory word k = 0xA000_0000+k: outputs 0xA000_0010..0xA000_0013 on consecutive cycles. First `out_valid` is 3 cycles after `start`. `done` pulses once.
- base=0xFFE, length=4: addresses issued 0xFFE, 0xFFF, 0x000, 0x001 in order.
- length=8, `out_ready`=0 for 20 cycles, then 1: exactly 4 strobes before the stall, no data lost or duplicated, all 8 words delivered in order.
- length=0: `done` pulses the cycle after `start`. `mem_chipselect` never asserts.
- length=100, `stop` at cycle 10 (and separately `reset` at cycle 10): within 1 cycle `out_valid`=0, `busy`=0, no further strobes, no `done`.
- With `WAVETABLE_READER_LOOP_EN` and `loop`=1, base=0x020, length=3: output address sequence 0x020, 0x021, 0x022, 0x020, … with no idle cycle, until `stop`.
